stream_max_finder: RTL
======================

Name: stream_max_finder

Overview:
- Sequential counterpart to the team's combinational min-of-four selector.
- Consumes a stream of unsigned samples over a valid/ready handshake, one frame at a time.
- At frame end, reports the frame maximum, the index of its first occurrence, the sample count and a truncation flag over a valid/ready result handshake.
- Sits between a sample producer and any peak-detect or normalisation consumer.

Parameters:
- WIDTH, 8, sample and max bit width (unsigned).
- MAX_LEN, 256, maximum samples per frame; power of two, >= 2.
- IDX_W, 8, index width = log2(MAX_LEN).

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  sample value (unsigned).
- in_valid  input  1  sample present.
- in_last  input  1  sample is the last of the frame; qualified by in_valid.
- in_ready  output  1  block accepts a sample this cycle.
- out_max  output  WIDTH  frame maximum.
- out_idx  output  IDX_W  index of the first sample equal to out_max (0-based).
- out_count  output  IDX_W+1  samples in the frame (1..MAX_LEN).
- out_trunc  output  1  frame was closed by the MAX_LEN limit, not by in_last.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.

Behaviour:
- Reset is synchronous and active-high; clock is clk, reset is reset.
- Reset values: out_valid=0, out_max=0, out_idx=0, out_count=0, out_trunc=0. State = ACCUM, so in_ready=1 in the first cycle after reset.
- Reset mid-frame or during HOLD discards the partial frame and any pending result. No result is emitted for it.
- A sample is accepted when in_valid && in_ready. A result is taken when out_valid && out_ready.
- State ACCUM:
  - in_ready=1, out_valid=0.
  - Counter cnt (IDX_W+1 bits) holds the number of samples accepted so far in the frame.
  - First accepted sample (cnt==0): run_max <= in_data, run_idx <= 0.
  - Later samples: if in_data > run_max (strict, unsigned), then run_max <= in_data and run_idx <= cnt. Ties keep the earlier index.
  - cnt increments on every accepted sample.
  - A frame closes when the accepted sample has in_last=1, or when cnt==MAX_LEN-1 (the MAX_LEN-th sample).
  - On close, in the same edge: load out_max/out_idx with the final values (including the closing sample), out_count <= cnt+1, out_trunc <= (in_last==0 && cnt==MAX_LEN-1), out_valid <= 1, cnt <= 0, state <= HOLD.
  - If the MAX_LEN-th sample also has in_last=1, out_trunc=0.
- Latency: out_valid rises on the clock edge that accepts the closing sample, i.e. it is visible the cycle after that sample is presented.
- State HOLD:
  - in_ready=0; all out_* stable.
  - On result taken: out_valid <= 0, state <= ACCUM.
  - in_ready is driven from registered state only, with no combinational path from out_ready. This costs one bubble cycle per frame (the take cycle).
- in_data and in_last are ignored when in_valid=0 or in_ready=0.
- A single-sample frame gives max=sample, idx=0, count=1.
- No wrap-around: cnt never exceeds MAX_LEN-1 before the frame closes.
- When out_valid=0 the out_* data retain their last result (not cleared), except on reset.

Test Plan:
- Reset then frame 5,9,3,9,1 (last on 1), out_ready=1 -> out_valid=1 one cycle after the last sample; max=9, idx=1, count=5, trunc=0; in_ready low for exactly 1 cycle (the take cycle).
- Single-sample frame 0x00 with last -> max=0, idx=0, count=1, trunc=0. Then frame 0xFF,0x00 -> max=255, idx=0, count=2.
- 256 ascending samples 0..255, no in_last -> closes on the 256th sample; max=255, idx=255, count=256, trunc=1. The next frame starts with cnt=0.
- Backpressure: out_ready held 0 for 10 cycles after the result -> out_* stable, in_ready=0, in_valid samples not consumed. Raise out_ready -> one take cycle, then in_ready=1.
- in_valid toggled randomly within a frame 7,2,8 (last) -> gaps have no effect; max=8, idx=2, count=3.
- Assert reset after 3 samples of a frame, then send 4,1 (last) -> result max=4, idx=0, count=2. No result for the discarded frame; all outputs equal reset values during and after the reset cycle.

Source files
------------

// File: rtl/stream_max_finder.sv
// Streaming frame maximum finder: accumulates unsigned samples per frame and
// reports max, first-occurrence index, sample count and truncation flag.
module stream_max_finder #(
    parameter int WIDTH   = 8,
    parameter int MAX_LEN = 256,
    parameter int IDX_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_max,
    output logic [IDX_W-1:0] out_idx,
    output logic [IDX_W:0]   out_count,
    output logic             out_trunc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             dbg_state
);

    // Handshakes: a sample moves when in_valid && in_ready, a result moves when
    // out_valid && out_ready; both ready/valid are driven from registered state only.
    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [IDX_W:0] LAST_CNT = (IDX_W + 1)'(MAX_LEN - 1);

    state_t           state;
    state_t           state_next;
    logic [IDX_W:0]   cnt;
    logic [WIDTH-1:0] run_max;
    logic [IDX_W-1:0] run_idx;

    logic             accept;
    logic             take;
    logic             at_limit;
    logic             closing;
    logic             new_peak;
    logic [WIDTH-1:0] cand_max;
    logic [IDX_W-1:0] cand_idx;

    always_comb begin
        in_ready   = (state == ACCUM);
        out_valid  = (state == HOLD);
        dbg_state  = (state == HOLD);
        accept     = in_valid && in_ready;
        take       = out_valid && out_ready;
        at_limit   = (cnt == LAST_CNT);
        closing    = accept && (in_last || at_limit);
        // Strict compare keeps the earliest index on ties.
        new_peak   = (cnt == '0) || (in_data > run_max);
        cand_max   = new_peak ? in_data : run_max;
        cand_idx   = new_peak ? cnt[IDX_W-1:0] : run_idx;
        state_next = state;
        case (state)
            ACCUM:   if (closing) state_next = HOLD;
            HOLD:    if (take) state_next = ACCUM;
            default: state_next = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            run_max   <= '0;
            run_idx   <= '0;
            out_max   <= '0;
            out_idx   <= '0;
            out_count <= '0;
            out_trunc <= 1'b0;
        end else if (accept) begin
            if (closing) begin
                out_max   <= cand_max;
                out_idx   <= cand_idx;
                out_count <= cnt + 1'b1;
                out_trunc <= !in_last && at_limit;
                cnt       <= '0;
            end else begin
                run_max <= cand_max;
                run_idx <= cand_idx;
                cnt     <= cnt + 1'b1;
            end
        end
    end

endmodule
